// File: rtl/pwm_audio_pkg.sv
// Constants and parameter checks shared by the stereo PWM audio output and capture blocks.
package pwm_audio_pkg;

  localparam int AUDIO_WIDTH  = 8;
  localparam int AUDIO_PERIOD = 255;

  // A full-duty frame counts PERIOD high cycles, so PERIOD must fit in WIDTH bits.
  function automatic bit period_fits(input int period, input int width);
    return (period >= 2) && (period <= (1 << width) - 1);
  endfunction

endpackage

// File: rtl/pwm_audio_stereo_in_if.sv
// Captured stereo sample stream: one left/right pair per valid, accepted when ready is high.
interface pwm_audio_stereo_in_if
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH = AUDIO_WIDTH
);

  logic [WIDTH-1:0] left_sample;
  logic [WIDTH-1:0] right_sample;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output left_sample,
    output right_sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_sample,
    input  right_sample,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/pwm_duty_capture.sv
// One PWM channel: input synchronizer plus high-cycle accumulator over a frame.
// count is combinational and includes the current synchronized bit, valid when frame_end is high.
module pwm_duty_capture
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH       = AUDIO_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             enable,
  input  logic             pwm,
  input  logic             frame_end,
  output logic [WIDTH-1:0] count
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   pwm_s;
  logic [WIDTH-1:0]       acc;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm};
    end
  end

  assign pwm_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      acc <= '0;
    end else if (!enable || frame_end) begin
      acc <= '0;
    end else begin
      acc <= acc + WIDTH'(pwm_s);
    end
  end

  // Last cycle of the frame is counted here rather than in acc, so acc restarts cleanly.
  assign count = acc + WIDTH'(pwm_s);

endmodule

// File: rtl/pwm_audio_stereo_in.sv
// Stereo PWM capture: counts high cycles per PERIOD-clock frame, one sample pair per frame.
// Pair visible one clock after frame end; a frame completing while the pair is unaccepted is dropped and flags overrun.
module pwm_audio_stereo_in
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH       = AUDIO_WIDTH,
  parameter int PERIOD      = AUDIO_PERIOD,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          aclr_n,
  input  logic                          enable,
  input  logic                          left,
  input  logic                          right,
  output logic                          overrun,
  input  logic                          clear_overrun,
  pwm_audio_stereo_in_if.master         smp
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(PERIOD - 1);

  if (!period_fits(PERIOD, WIDTH)) begin : g_bad_period
    $error("pwm_audio_stereo_in: PERIOD must be in 2..2**WIDTH-1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pwm_audio_stereo_in: SYNC_STAGES must be at least 2");
  end

  logic [WIDTH-1:0] frame_cnt;
  logic             frame_end;
  logic             drop;
  logic [WIDTH-1:0] left_count;
  logic [WIDTH-1:0] right_count;
  logic [WIDTH-1:0] left_q;
  logic [WIDTH-1:0] right_q;
  logic             valid_q;

  assign frame_end = enable && (frame_cnt == LAST_CNT);
  assign drop      = frame_end && valid_q && !smp.sample_ready;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      frame_cnt <= '0;
    end else if (!enable || frame_end) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  pwm_duty_capture #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_left (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .enable    (enable),
    .pwm       (left),
    .frame_end (frame_end),
    .count     (left_count)
  );

  pwm_duty_capture #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_right (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .enable    (enable),
    .pwm       (right),
    .frame_end (frame_end),
    .count     (right_count)
  );

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else if (frame_end) begin
      if (!valid_q || smp.sample_ready) begin
        left_q  <= left_count;
        right_q <= right_count;
        valid_q <= 1'b1;
      end
    end else if (smp.sample_ready) begin
      valid_q <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign smp.left_sample  = left_q;
  assign smp.right_sample = right_q;
  assign smp.sample_valid = valid_q;

endmodule

// File: tb/tb_pwm_audio_stereo_in.sv
// Directed bench for pwm_audio_stereo_in: expected sample pairs queued as stimulus is set up, popped as pairs appear.
module tb_pwm_audio_stereo_in;

  localparam int P = 255;
  localparam int W = 8;

  logic clk = 1'b0;
  logic aclr_n = 1'b0;
  logic enable = 1'b0;
  logic dc_l = 1'b0;
  logic dc_r = 1'b0;
  logic clear_overrun = 1'b0;
  logic overrun;
  logic left_pin;
  logic right_pin;

  bit pwm_run = 1'b0;
  int l_duty = 0;
  int r_duty = 0;
  int phase_off = 0;
  int gcnt = 0;

  int n_pass = 0;
  int n_checks = 0;
  int exp_q[$];

  pwm_audio_stereo_in_if #(.WIDTH(W)) smp();

  pwm_audio_stereo_in #(
    .WIDTH       (W),
    .PERIOD      (P),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .aclr_n        (aclr_n),
    .enable        (enable),
    .left          (left_pin),
    .right         (right_pin),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .smp           (smp)
  );

  always #5 clk = ~clk;

  // Free-running stand-in for the stereo PWM transmitter, period P.
  always @(negedge clk) gcnt <= (gcnt == P - 1) ? 0 : gcnt + 1;

  assign left_pin  = pwm_run ? (((gcnt + phase_off) % P) < l_duty) : dc_l;
  assign right_pin = pwm_run ? (((gcnt + phase_off) % P) < r_duty) : dc_r;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int pair();
    return int'({smp.left_sample, smp.right_sample});
  endfunction

  task automatic push_pair(input int l, input int r);
    exp_q.push_back((l << 8) | r);
  endtask

  task automatic check_pair(input string tag);
    int exp;
    chk({tag, "_queued"}, int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk(tag, pair(), exp);
    end
  endtask

  // Advances at least one falling edge, stops on the first one that shows sample_valid.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (n < 2 * P + 10) begin
      @(negedge clk);
      n++;
      if (smp.sample_valid) break;
    end
    chk({tag, "_seen"}, int'(smp.sample_valid), 1);
  endtask

  task automatic skip(input int k);
    int n;
    repeat (k) wait_valid("skip", n);
  endtask

  initial begin
    int n;
    int bad;

    // Reset with lines high and enable on
    smp.sample_ready = 1'b0;
    enable = 1'b1;
    dc_l = 1'b1;
    dc_r = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(smp.sample_valid), 0);
    chk("rst_pair", pair(), 0);
    chk("rst_overrun", int'(overrun), 0);

    // First frame after release is short by the synchronizer depth
    aclr_n = 1'b1;
    push_pair(P - 2, P - 2);
    wait_valid("first", n);
    chk("first_latency", n, P);
    check_pair("first_pair");
    repeat (P + 100) @(negedge clk);
    chk("hold_valid", int'(smp.sample_valid), 1);
    chk("hold_pair", pair(), ((P - 2) << 8) | (P - 2));
    chk("hold_overrun", int'(overrun), 1);
    @(posedge clk);
    #2 aclr_n = 1'b0;
    #1;
    chk("arst_valid", int'(smp.sample_valid), 0);
    chk("arst_pair", pair(), 0);
    chk("arst_overrun", int'(overrun), 0);
    repeat (2) @(negedge clk);
    smp.sample_ready = 1'b1;
    aclr_n = 1'b1;
    push_pair(P - 2, P - 2);
    wait_valid("rerelease", n);
    chk("rerelease_latency", n, P);
    check_pair("rerelease_pair");

    // DC levels
    dc_r = 1'b0;
    skip(2);
    push_pair(P, 0);
    push_pair(P, 0);
    wait_valid("dc_a", n);
    check_pair("dc_a_pair");
    wait_valid("dc_b", n);
    check_pair("dc_b_pair");
    chk("dc_spacing", n, P);
    @(negedge clk);
    chk("dc_pulse_width", int'(smp.sample_valid), 0);

    // Loopback from the PWM source
    pwm_run = 1'b1;
    l_duty = 127;
    r_duty = 0;
    skip(2);
    push_pair(127, 0);
    push_pair(127, 0);
    repeat (2) begin
      wait_valid("loop_a", n);
      check_pair("loop_a_pair");
    end
    r_duty = 127;
    skip(2);
    push_pair(127, 127);
    wait_valid("loop_b", n);
    check_pair("loop_b_pair");
    phase_off = $urandom_range(1, P - 1);
    skip(2);
    push_pair(127, 127);
    push_pair(127, 127);
    repeat (2) begin
      wait_valid("loop_phase", n);
      check_pair("loop_phase_pair");
    end
    l_duty = 200;
    r_duty = 55;
    skip(2);
    push_pair(200, 55);
    wait_valid("loop_c", n);
    check_pair("loop_c_pair");

    // Backpressure
    l_duty = 64;
    r_duty = 0;
    skip(2);
    @(negedge clk);
    smp.sample_ready = 1'b0;
    push_pair(64, 0);
    wait_valid("bp_load", n);
    check_pair("bp_load_pair");
    chk("bp_no_overrun_yet", int'(overrun), 0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (!smp.sample_valid || pair() != (64 << 8)) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_overrun", int'(overrun), 1);
    smp.sample_ready = 1'b1;
    push_pair(64, 0);
    check_pair("bp_accept_pair");
    @(negedge clk);
    chk("bp_valid_clears", int'(smp.sample_valid), 0);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    chk("bp_clear", int'(overrun), 0);
    smp.sample_ready = 1'b0;
    push_pair(64, 0);
    wait_valid("bp_reload", n);
    check_pair("bp_reload_pair");
    repeat (254) @(negedge clk);
    chk("bp_before_drop", int'(overrun), 0);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    chk("bp_set_wins", int'(overrun), 1);
    smp.sample_ready = 1'b1;
    push_pair(64, 0);
    check_pair("bp_drain_pair");
    @(negedge clk);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;

    // Enable gap with a pending sample
    pwm_run = 1'b0;
    dc_l = 1'b1;
    dc_r = 1'b0;
    skip(2);
    @(negedge clk);
    smp.sample_ready = 1'b0;
    push_pair(P, 0);
    wait_valid("gap_pending", n);
    check_pair("gap_pending_pair");
    repeat (100) @(negedge clk);
    enable = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!smp.sample_valid) bad++;
    end
    chk("gap_valid_held", bad, 0);
    chk("gap_no_overrun", int'(overrun), 0);
    smp.sample_ready = 1'b1;
    push_pair(P, 0);
    check_pair("gap_accept_pair");
    @(negedge clk);
    enable = 1'b1;
    push_pair(P, 0);
    wait_valid("gap_resume", n);
    chk("gap_resume_latency", n, P);
    check_pair("gap_resume_pair");

    // Boundary: left high only on the frame's last counted cycle, right high throughout
    enable = 1'b0;
    dc_l = 1'b0;
    dc_r = 1'b1;
    repeat (5) @(negedge clk);
    repeat (3) push_pair(1, P);
    for (int k = 0; k <= 3 * P; k++) begin
      if (smp.sample_valid) check_pair("boundary_pair");
      enable = 1'b1;
      dc_l = ((k % P) == P - 3);
      @(negedge clk);
    end
    chk("boundary_all_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
